perf_counter_snapshot_streamer: RTL and testbench



---
 rtl/perf_monitor_pkg.sv | 23 ++
 rtl/perf_delta_lane.sv | 22 ++
 rtl/perf_counter_snapshot_streamer.sv | 88 ++++++++
 tb/tb_perf_counter_snapshot_streamer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_monitor_pkg.sv
// Shared constants and types for the performance-monitor snapshot path.
// Field offsets describe the default-sized {overrun, seq, deltas} word.
package perf_monitor_pkg;

  localparam int N_DEF      = 115;
  localparam int W_DEF      = 7;
  localparam int SEQ_W_DEF  = 8;
  localparam int DROP_W_DEF = 16;

  localparam int TDATA_W     = N_DEF * W_DEF + SEQ_W_DEF + 1;
  localparam int SEQ_LSB     = N_DEF * W_DEF;
  localparam int OVERRUN_BIT = TDATA_W - 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } snap_state_e;

  function automatic int tdata_width(input int n, input int w, input int s);
    return n * w + s + 1;
  endfunction

endpackage

// File: rtl/perf_delta_lane.sv
// One counter lane: baseline register plus modulo-2^W delta since that baseline.
// Wrap-around is handled implicitly by the truncating subtract.
module perf_delta_lane #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] cnt,
  input  logic         load,
  output logic [W-1:0] delta
);

  logic [W-1:0] base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    base <= '0;
    else if (load) base <= cnt;
  end

  assign delta = cnt - base;

endmodule

// File: rtl/perf_counter_snapshot_streamer.sv
// Snapshots wrapping event counters into delta words on a valid/ready stream,
// tagging each with a sequence number and an overrun flag for refused triggers.
module perf_counter_snapshot_streamer
  import perf_monitor_pkg::*;
#(
  parameter int INPUT_EVENT_BITMAP_WIDTH = N_DEF,
  parameter int COUNTER_WIDTH            = W_DEF,
  parameter int SEQ_WIDTH                = SEQ_W_DEF,
  parameter int DROP_WIDTH               = DROP_W_DEF
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [INPUT_EVENT_BITMAP_WIDTH*COUNTER_WIDTH-1:0]     counters_flat,
  input  logic                                                  trigger,
  input  logic                                                  clear_baseline,
  output logic [INPUT_EVENT_BITMAP_WIDTH*COUNTER_WIDTH+SEQ_WIDTH:0] m_tdata,
  output logic                                                  m_tvalid,
  input  logic                                                  m_tready,
  output logic [DROP_WIDTH-1:0]                                 dropped_count
);

  localparam int N = INPUT_EVENT_BITMAP_WIDTH;
  localparam int W = COUNTER_WIDTH;

  snap_state_e state_q, state_d;

  logic [N-1:0][W-1:0]   deltas;
  logic [SEQ_WIDTH-1:0]  seq_q;
  logic                  pend_ovr_q;
  logic                  accept, refuse;

  // clear_baseline swallows a same-cycle trigger entirely (neither accepted nor dropped)
  assign accept = trigger && !clear_baseline && (state_q == ST_EMPTY || m_tready);
  assign refuse = trigger && !clear_baseline && state_q == ST_FULL && !m_tready;

  for (genvar g = 0; g < N; g++) begin : g_lane
    perf_delta_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (counters_flat[g*W +: W]),
      .load  (accept || clear_baseline),
      .delta (deltas[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    m_tvalid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        m_tvalid = 1'b1;
        if (!accept && m_tready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata    <= '0;
      seq_q      <= '0;
      pend_ovr_q <= 1'b0;
    end else begin
      if (accept) begin
        m_tdata <= {pend_ovr_q, seq_q, deltas};
        seq_q   <= seq_q + SEQ_WIDTH'(1);
      end
      if (clear_baseline || accept) pend_ovr_q <= 1'b0;
      else if (refuse)              pend_ovr_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dropped_count <= '0;
    else if (refuse && dropped_count != {DROP_WIDTH{1'b1}})
      dropped_count <= dropped_count + DROP_WIDTH'(1);
  end

endmodule

// File: tb/tb_perf_counter_snapshot_streamer.sv
// Directed bench for the snapshot streamer: wrap, overrun, back-to-back, clear, reset.
module tb_perf_counter_snapshot_streamer;

  localparam int N   = 115;
  localparam int W   = 7;
  localparam int SW  = 8;
  localparam int DW  = 16;
  localparam int TDW = N * W + SW + 1;

  logic             clk;
  logic             rst_n;
  logic [N*W-1:0]   counters_flat;
  logic             trigger;
  logic             clear_baseline;
  logic [TDW-1:0]   m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    dropped_count;

  int total = 0;
  int bad   = 0;

  perf_counter_snapshot_streamer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .counters_flat  (counters_flat),
    .trigger        (trigger),
    .clear_baseline (clear_baseline),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .dropped_count  (dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [TDW-1:0] obs, input logic [TDW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are read on the falling edge after a rising edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cnt(input int i, input int v);
    counters_flat[i*W +: W] = W'(v);
  endtask

  function automatic logic [W-1:0] delta_of(input int i);
    return m_tdata[i*W +: W];
  endfunction

  function automatic logic [SW-1:0] seq_of();
    return m_tdata[N*W +: SW];
  endfunction

  function automatic logic ovr_of();
    return m_tdata[TDW-1];
  endfunction

  logic [TDW-1:0] saved;
  logic [SW-1:0]  prev_seq;
  logic           saw_wrap;

  initial begin
    rst_n          = 1'b0;
    counters_flat  = '0;
    trigger        = 1'b0;
    clear_baseline = 1'b0;
    m_tready       = 1'b0;
    step();
    chk("rst_tvalid", TDW'(m_tvalid), TDW'(0));
    chk("rst_tdata", m_tdata, '0);
    chk("rst_dropped", TDW'(dropped_count), TDW'(0));
    rst_n = 1'b1;
    step();

    // first snapshot from zero baseline
    set_cnt(0, 5); set_cnt(114, 9);
    trigger = 1'b1; m_tready = 1'b1;
    step();
    trigger = 1'b0;
    chk("s1_tvalid", TDW'(m_tvalid), TDW'(1));
    chk("s1_delta0", TDW'(delta_of(0)), TDW'(5));
    chk("s1_delta114", TDW'(delta_of(114)), TDW'(9));
    chk("s1_delta1", TDW'(delta_of(1)), TDW'(0));
    chk("s1_seq", TDW'(seq_of()), TDW'(0));
    chk("s1_ovr", TDW'(ovr_of()), TDW'(0));
    step();
    chk("s1_xfer_empty", TDW'(m_tvalid), TDW'(0));

    // baseline 120 via clear, then counter wraps to 3: (3-120) mod 128 = 11
    set_cnt(0, 120); clear_baseline = 1'b1;
    step();
    clear_baseline = 1'b0;
    chk("clr_no_word", TDW'(m_tvalid), TDW'(0));
    set_cnt(0, 3); trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("wrap_delta0", TDW'(delta_of(0)), TDW'(11));
    chk("wrap_delta114", TDW'(delta_of(114)), TDW'(0));
    chk("wrap_seq", TDW'(seq_of()), TDW'(1));
    step();

    // hold a word with ready low; three refused triggers
    m_tready = 1'b0; set_cnt(0, 10); trigger = 1'b1;
    step();
    chk("ovA_delta0", TDW'(delta_of(0)), TDW'(7));
    chk("ovA_seq", TDW'(seq_of()), TDW'(2));
    saved = m_tdata;
    for (int k = 0; k < 3; k++) begin
      set_cnt(0, 20 + 10 * k);
      step();
    end
    trigger = 1'b0;
    chk("ov_dropped3", TDW'(dropped_count), TDW'(3));
    chk("ov_tdata_stable", m_tdata, saved);
    chk("ov_tvalid_held", TDW'(m_tvalid), TDW'(1));
    // back-to-back accept; delta spans from the last accepted baseline (10)
    m_tready = 1'b1; set_cnt(0, 50); trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("ovB_tvalid", TDW'(m_tvalid), TDW'(1));
    chk("ovB_ovr", TDW'(ovr_of()), TDW'(1));
    chk("ovB_seq", TDW'(seq_of()), TDW'(3));
    chk("ovB_delta0", TDW'(delta_of(0)), TDW'(40));
    step();
    chk("ovB_xfer_empty", TDW'(m_tvalid), TDW'(0));

    // trigger every cycle for 300 cycles, seq wraps 255 -> 0
    saw_wrap = 1'b0; prev_seq = '0;
    for (int k = 0; k < 300; k++) begin
      set_cnt(0, (51 + k) % 128); trigger = 1'b1; m_tready = 1'b1;
      step();
      chk("b2b_tvalid", TDW'(m_tvalid), TDW'(1));
      chk("b2b_seq", TDW'(seq_of()), TDW'((4 + k) % 256));
      chk("b2b_delta0", TDW'(delta_of(0)), TDW'(1));
      chk("b2b_ovr", TDW'(ovr_of()), TDW'(0));
      if (k > 0 && prev_seq == 8'd255 && seq_of() == 8'd0) saw_wrap = 1'b1;
      prev_seq = seq_of();
    end
    trigger = 1'b0;
    step();
    chk("b2b_seq_wrapped", TDW'(saw_wrap), TDW'(1));
    chk("b2b_end_empty", TDW'(m_tvalid), TDW'(0));
    chk("b2b_no_new_drops", TDW'(dropped_count), TDW'(3));

    // clear_baseline wins over trigger
    set_cnt(0, 40); clear_baseline = 1'b1; trigger = 1'b1;
    step();
    clear_baseline = 1'b0; trigger = 1'b0;
    chk("clrtrig_no_word", TDW'(m_tvalid), TDW'(0));
    chk("clrtrig_no_drop", TDW'(dropped_count), TDW'(3));
    set_cnt(0, 45); trigger = 1'b1;
    step();
    trigger = 1'b0; m_tready = 1'b0;
    chk("clrtrig_delta0", TDW'(delta_of(0)), TDW'(5));
    chk("clrtrig_seq", TDW'(seq_of()), TDW'(48));
    chk("clrtrig_ovr", TDW'(ovr_of()), TDW'(0));
    saved = m_tdata;
    // refuse one trigger, then clear_baseline drops the pending overrun
    set_cnt(0, 50); trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("clrovr_dropped", TDW'(dropped_count), TDW'(4));
    set_cnt(0, 60); clear_baseline = 1'b1;
    step();
    clear_baseline = 1'b0;
    chk("clrovr_tvalid_kept", TDW'(m_tvalid), TDW'(1));
    chk("clrovr_tdata_kept", m_tdata, saved);
    m_tready = 1'b1; set_cnt(0, 62); trigger = 1'b1;
    step();
    trigger = 1'b0; m_tready = 1'b0;
    chk("clrovr_ovr", TDW'(ovr_of()), TDW'(0));
    chk("clrovr_delta0", TDW'(delta_of(0)), TDW'(2));
    chk("clrovr_seq", TDW'(seq_of()), TDW'(49));
    step();
    chk("pre_rst_tvalid", TDW'(m_tvalid), TDW'(1));

    // asynchronous reset mid-cycle discards the held word
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", TDW'(m_tvalid), TDW'(0));
    chk("arst_tdata", m_tdata, '0);
    chk("arst_dropped", TDW'(dropped_count), TDW'(0));
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("arst_trig_ignored", TDW'(m_tvalid), TDW'(0));
    rst_n = 1'b1;
    set_cnt(0, 7); trigger = 1'b1; m_tready = 1'b1;
    step();
    trigger = 1'b0;
    chk("post_rst_tvalid", TDW'(m_tvalid), TDW'(1));
    chk("post_rst_seq", TDW'(seq_of()), TDW'(0));
    chk("post_rst_delta0", TDW'(delta_of(0)), TDW'(7));
    chk("post_rst_delta114", TDW'(delta_of(114)), TDW'(9));
    chk("post_rst_ovr", TDW'(ovr_of()), TDW'(0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
